// File: rtl/scs8hd_misr_pkg.sv
// rtl/scs8hd_misr_pkg.sv - shared state enum, counter width and MISR step function
package scs8hd_misr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        FIN     = 2'd2
    } state_t;

    localparam int NCYC_W     = 16;
    localparam int MISR_MAX_W = 64;

    // Callers zero-extend to MISR_MAX_W, so the shift brings a 0 into bit WIDTH-1.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] d,
        input logic [MISR_MAX_W-1:0] poly
    );
        return (sig >> 1) ^ (sig[0] ? poly : '0) ^ d;
    endfunction

endpackage

// File: rtl/scs8hd_misr_core.sv
// rtl/scs8hd_misr_core.sv - WIDTH-bit signature register with load, compaction step and scan shift
module scs8hd_misr_core
    import scs8hd_misr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             step,
    input  logic             shift,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] SIG
);

    logic [WIDTH-1:0] step_value;

    assign step_value = WIDTH'(misr_step(MISR_MAX_W'(SIG), MISR_MAX_W'(D), MISR_MAX_W'(POLY)));

    always_ff @(posedge CLK) begin
        if (RESET || load) begin
            SIG <= SEED;
        end else if (step) begin
            SIG <= step_value;
        end else if (shift) begin
            SIG <= {SI, SIG[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/scs8hd_misr_capture.sv
// rtl/scs8hd_misr_capture.sv - MISR capture FSM and run counter; SCS8HD_MISR_COMPARE_EN adds GOLD/PASS
module scs8hd_misr_capture
    import scs8hd_misr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [NCYC_W-1:0] NCYC,
    input  logic [WIDTH-1:0]  D,
    input  logic              SE,
    input  logic              SI,
    output logic              SO,
    output logic [WIDTH-1:0]  SIG,
    output logic              BUSY,
    output logic              DONE
`ifdef SCS8HD_MISR_COMPARE_EN
    ,
    input  logic [WIDTH-1:0]  GOLD,
    output logic              PASS
`endif
);

    state_t            state;
    state_t            state_next;
    logic [NCYC_W-1:0] cnt;
    logic              load;
    logic              step;
    logic              shift;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                // START wins over SE in the same cycle.
                if (START) begin
                    load       = 1'b1;
                    state_next = (NCYC == '0) ? FIN : COMPACT;
                end else if (SE) begin
                    shift = 1'b1;
                end
            end
            COMPACT: begin
                step = 1'b1;
                if (cnt == NCYC_W'(1)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (state == IDLE && START) begin
            cnt <= NCYC;
        end else if (state == COMPACT) begin
            cnt <= cnt - NCYC_W'(1);
        end
    end

    scs8hd_misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (load),
        .step  (step),
        .shift (shift),
        .D     (D),
        .SI    (SI),
        .SIG   (SIG)
    );

    assign SO   = SIG[0];
    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

`ifdef SCS8HD_MISR_COMPARE_EN
    logic [WIDTH-1:0] final_sig;

    // Value SIG will take on the last compaction edge, compared as FIN is entered.
    assign final_sig = WIDTH'(misr_step(MISR_MAX_W'(SIG), MISR_MAX_W'(D), MISR_MAX_W'(POLY)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PASS <= 1'b0;
        end else if (state == IDLE && START) begin
            PASS <= (NCYC == '0) ? (SEED == GOLD) : 1'b0;
        end else if (state == COMPACT && cnt == NCYC_W'(1)) begin
            PASS <= (final_sig == GOLD);
        end
    end
`endif

endmodule
